// File: rtl/bus_bridge_periph_pkg.sv
// Shared constants for the CPU bus bridge: peripheral page, register offsets and the
// 7-segment hex table.
package bus_bridge_periph_pkg;

   localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

   // Byte offsets inside the peripheral page; the low 2 bits are ignored on decode.
   localparam logic [11:0] ADDR_DIG   = 12'h000;
   localparam logic [11:0] ADDR_TIMER = 12'h020;
   localparam logic [11:0] ADDR_LED   = 12'h060;
   localparam logic [11:0] ADDR_SW    = 12'h070;
   localparam logic [11:0] ADDR_BTN   = 12'h078;

   localparam int unsigned LED_W = 24;
   localparam int unsigned SW_W  = 24;
   localparam int unsigned BTN_W = 5;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_DIG,
      SEL_TIMER,
      SEL_LED,
      SEL_SW,
      SEL_BTN
   } periph_sel_e;

   // Active-low {DP,G,F,E,D,C,B,A}; DP held off.
   function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
      logic [7:0] seg;
      case (hex)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bus_bridge_periph_seg7_scan.sv
// 8-digit multiplexed 7-segment scan driver: prescaler, digit index and hex decode.
module bus_bridge_periph_seg7_scan
   import bus_bridge_periph_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dig_data,
   output logic [7:0]  dig_en,
   output logic [7:0]  dig_seg
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] presc;
   logic [2:0]    idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PW'(SCAN_DIV - 1)) begin
         presc <= '0;
         idx   <= idx + 3'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Decoded straight from registers so each digit stays glitch-free while lit.
   assign dig_en  = ~(8'b1 << idx);
   assign dig_seg = hex_to_seg(dig_data[{idx, 2'b00} +: 4]);

endmodule

// File: rtl/bus_bridge_periph.sv
// CPU data-bus responder: routes accesses to DRAM or to the on-chip peripheral page
// (display, timer, LEDs, switches, buttons).
module bus_bridge_periph
   import bus_bridge_periph_pkg::*;
#(
   parameter int unsigned DRAM_AW  = 14,
   parameter int unsigned SCAN_DIV = 20000
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   input  logic [31:0]        Bus_addr,
   input  logic               Bus_wen,
   input  logic [31:0]        Bus_wdata,
   output logic [31:0]        Bus_rdata,
   output logic [DRAM_AW-1:0] dram_addr,
   output logic               dram_we,
   output logic [31:0]        dram_wdata,
   input  logic [31:0]        dram_rdata,
   input  logic [SW_W-1:0]    sw,
   input  logic [BTN_W-1:0]   btn,
   output logic [LED_W-1:0]   led,
   output logic [7:0]         dig_en,
   output logic [7:0]         dig_seg
);

   logic              periph;
   logic              wr;
   periph_sel_e       sel;
   logic [31:0]       dig_data;
   logic [31:0]       timer;
   logic [SW_W-1:0]   sw_s1, sw_s2;
   logic [BTN_W-1:0]  btn_s1, btn_s2;
   logic              unused_addr_lsb;

   assign periph          = (Bus_addr[31:12] == PERIPH_BASE);
   assign wr              = Bus_wen & periph;
   assign unused_addr_lsb = ^Bus_addr[1:0];

   assign dram_addr  = Bus_addr[DRAM_AW+1:2];
   assign dram_we    = Bus_wen & ~periph;
   assign dram_wdata = Bus_wdata;

   // Word-level register select within the peripheral page.
   always_comb begin
      sel = SEL_NONE;
      if (periph) begin
         case (Bus_addr[11:2])
            ADDR_DIG[11:2]:   sel = SEL_DIG;
            ADDR_TIMER[11:2]: sel = SEL_TIMER;
            ADDR_LED[11:2]:   sel = SEL_LED;
            ADDR_SW[11:2]:    sel = SEL_SW;
            ADDR_BTN[11:2]:   sel = SEL_BTN;
            default:          sel = SEL_NONE;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         dig_data <= '0;
         timer    <= '0;
         led      <= '0;
         sw_s1    <= '0;
         sw_s2    <= '0;
         btn_s1   <= '0;
         btn_s2   <= '0;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         btn_s1 <= btn;
         btn_s2 <= btn_s1;
         // A timer write wins over the increment for that one cycle.
         timer  <= (wr && sel == SEL_TIMER) ? Bus_wdata : timer + 32'd1;
         if (wr && sel == SEL_DIG) dig_data <= Bus_wdata;
         if (wr && sel == SEL_LED) led      <= Bus_wdata[LED_W-1:0];
      end
   end

   // Reads see register state before the edge so the CPU can sample in the same cycle.
   always_comb begin
      Bus_rdata = '0;
      if (!periph) begin
         Bus_rdata = dram_rdata;
      end else begin
         case (sel)
            SEL_DIG:   Bus_rdata = dig_data;
            SEL_TIMER: Bus_rdata = timer;
            SEL_LED:   Bus_rdata = 32'(led);
            SEL_SW:    Bus_rdata = 32'(sw_s2);
            SEL_BTN:   Bus_rdata = 32'(btn_s2);
            default:   Bus_rdata = '0;
         endcase
      end
   end

   bus_bridge_periph_seg7_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk      (cpu_clk),
      .rst      (cpu_rst),
      .dig_data (dig_data),
      .dig_en   (dig_en),
      .dig_seg  (dig_seg)
   );

endmodule

// File: tb/tb_bus_bridge_periph.sv
// Directed self-checking bench for bus_bridge_periph with a fast display scan (SCAN_DIV=4).
module tb_bus_bridge_periph;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [31:0] Bus_addr;
   logic        Bus_wen;
   logic [31:0] Bus_wdata;
   logic [31:0] Bus_rdata;
   logic [13:0] dram_addr;
   logic        dram_we;
   logic [31:0] dram_wdata;
   logic [31:0] dram_rdata;
   logic [23:0] sw;
   logic [4:0]  btn;
   logic [23:0] led;
   logic [7:0]  dig_en;
   logic [7:0]  dig_seg;

   int tests_run    = 0;
   int tests_failed = 0;

   bus_bridge_periph #(
      .DRAM_AW  (14),
      .SCAN_DIV (4)
   ) dut (
      .cpu_clk    (cpu_clk),
      .cpu_rst    (cpu_rst),
      .Bus_addr   (Bus_addr),
      .Bus_wen    (Bus_wen),
      .Bus_wdata  (Bus_wdata),
      .Bus_rdata  (Bus_rdata),
      .dram_addr  (dram_addr),
      .dram_we    (dram_we),
      .dram_wdata (dram_wdata),
      .dram_rdata (dram_rdata),
      .sw         (sw),
      .btn        (btn),
      .led        (led),
      .dig_en     (dig_en),
      .dig_seg    (dig_seg)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge cpu_clk);
      #1;
   endtask

   initial begin
      cpu_rst    = 1'b1;
      Bus_addr   = 32'h0;
      Bus_wen    = 1'b0;
      Bus_wdata  = 32'h0;
      dram_rdata = 32'h0;
      sw         = 24'h0;
      btn        = 5'h0;

      // Reset state
      #12;
      check("rst_led",    32'(led),     32'h0);
      check("rst_dig_en", 32'(dig_en),  32'hFE);
      check("rst_seg",    32'(dig_seg), 32'hC0);
      check("rst_we",     32'(dram_we), 32'h0);
      Bus_addr = 32'hFFFFF020;
      #10;
      cpu_rst = 1'b0;
      #1;
      check("timer_first", Bus_rdata, 32'h0);
      tick(1);

      // LED write
      Bus_addr  = 32'hFFFFF060;
      Bus_wen   = 1'b1;
      Bus_wdata = 32'h00ABCDEF;
      #1;
      check("led_wr_dram_we", 32'(dram_we), 32'h0);
      check("led_pre_edge",   Bus_rdata,    32'h0);
      tick(1);
      Bus_wen = 1'b0;
      #1;
      check("led_out",  32'(led), 32'hABCDEF);
      check("led_read", Bus_rdata, 32'h00ABCDEF);
      Bus_wdata = 32'h00111111;
      tick(1);
      check("led_no_wen", 32'(led), 32'hABCDEF);

      // Unmapped peripheral address
      Bus_addr = 32'hFFFFF040;
      Bus_wen  = 1'b1;
      tick(1);
      Bus_wen = 1'b0;
      #1;
      check("unmapped_read", Bus_rdata, 32'h0);
      check("unmapped_drop", 32'(led), 32'hABCDEF);

      // DRAM write/read
      Bus_addr  = 32'h00000104;
      Bus_wen   = 1'b1;
      Bus_wdata = 32'h12345678;
      #1;
      check("dram_we",    32'(dram_we),   32'h1);
      check("dram_addr",  32'(dram_addr), 32'h041);
      check("dram_wdata", dram_wdata,     32'h12345678);
      tick(1);
      Bus_wen    = 1'b0;
      dram_rdata = 32'hCAFEF00D;
      #1;
      check("dram_we_off", 32'(dram_we), 32'h0);
      check("dram_rdata",  Bus_rdata,    32'hCAFEF00D);
      check("led_kept",    32'(led),     32'hABCDEF);

      // Timer load and wrap
      Bus_addr  = 32'hFFFFF020;
      Bus_wen   = 1'b1;
      Bus_wdata = 32'h00000100;
      tick(1);
      Bus_wen = 1'b0;
      #1;
      check("timer_load", Bus_rdata, 32'h100);
      tick(1);
      check("timer_inc", Bus_rdata, 32'h101);
      Bus_wen   = 1'b1;
      Bus_wdata = 32'hFFFFFFFF;
      tick(1);
      Bus_wen = 1'b0;
      #1;
      check("timer_max",  Bus_rdata, 32'hFFFFFFFF);
      tick(1);
      check("timer_wrap", Bus_rdata, 32'h0);
      tick(3);
      check("timer_run", Bus_rdata, 32'h3);
      #2;
      cpu_rst = 1'b1;
      #1;
      check("timer_rst",     Bus_rdata,   32'h0);
      check("led_rst",       32'(led),    32'h0);
      check("dig_en_rst_mid", 32'(dig_en), 32'hFE);
      #1;
      cpu_rst = 1'b0;
      tick(1);

      // Synchronizers: two edges of latency
      sw       = 24'h00F0F0;
      btn      = 5'b10001;
      Bus_addr = 32'hFFFFF070;
      tick(1);
      check("sw_1edge", Bus_rdata, 32'h0);
      Bus_addr = 32'hFFFFF078;
      #1;
      check("btn_1edge", Bus_rdata, 32'h0);
      tick(1);
      check("btn_2edge", Bus_rdata, 32'h00000011);
      Bus_addr  = 32'hFFFFF070;
      #1;
      check("sw_2edge", Bus_rdata, 32'h0000F0F0);
      Bus_wen   = 1'b1;
      Bus_wdata = 32'hFFFFFFFF;
      tick(1);
      Bus_wen = 1'b0;
      #1;
      check("sw_wr_ignored", Bus_rdata, 32'h0000F0F0);

      // Display scan from a known phase: reset, then DIG write on the first edge
      cpu_rst = 1'b1;
      #2;
      cpu_rst   = 1'b0;
      Bus_addr  = 32'hFFFFF000;
      Bus_wen   = 1'b1;
      Bus_wdata = 32'h87654321;
      tick(1);
      Bus_wen = 1'b0;
      #1;
      check("scan_d0_en",  32'(dig_en),  32'hFE);
      check("scan_d0_seg", 32'(dig_seg), 32'hF9);
      check("dig_read",    Bus_rdata,    32'h87654321);
      tick(2);
      check("scan_d0_hold", 32'(dig_en), 32'hFE);
      tick(1);
      check("scan_d1_en",  32'(dig_en),  32'hFD);
      check("scan_d1_seg", 32'(dig_seg), 32'hA4);
      tick(27);
      check("scan_d7_en",  32'(dig_en),  32'h7F);
      check("scan_d7_seg", 32'(dig_seg), 32'h80);
      tick(1);
      check("scan_wrap_en",  32'(dig_en),  32'hFE);
      check("scan_wrap_seg", 32'(dig_seg), 32'hF9);

      // DIG write mid-digit updates the lit digit without moving the scan
      Bus_wen   = 1'b1;
      Bus_wdata = 32'h0000000A;
      tick(1);
      Bus_wen = 1'b0;
      #1;
      check("dig_upd_en",  32'(dig_en),  32'hFE);
      check("dig_upd_seg", 32'(dig_seg), 32'h88);
      tick(3);
      check("dig_upd_d1_en",  32'(dig_en),  32'hFD);
      check("dig_upd_d1_seg", 32'(dig_seg), 32'hC0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
